// File: rtl/cpu_sequencer_if.sv
// Handshake/control bundle between the RV32I multi-cycle sequencer and the
// decoder, memories and datapath strobes. The sequencer uses the master side.
interface cpu_sequencer_if;
  // inputs to the sequencer
  logic       imem_ready;
  logic       dmem_ready;
  logic       load_memory;
  logic       store_memory;
  logic       reg_we;
  logic       ebreak;
  // outputs from the sequencer
  logic       imem_req;
  logic       ir_we;
  logic       dmem_req;
  logic       dmem_we;
  logic       rf_we;
  logic       pc_we;
  logic       halted;
  logic       bus_error;
  logic [2:0] state_o;

  modport master (
    input  imem_ready, dmem_ready, load_memory, store_memory, reg_we, ebreak,
    output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halted, bus_error,
           state_o
  );

  modport slave (
    output imem_ready, dmem_ready, load_memory, store_memory, reg_we, ebreak,
    input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halted, bus_error,
           state_o
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the RV32I core:
// FETCH -> DECODE -> EXECUTE -> [MEM] -> WRITEBACK, with sticky HALT (ebreak)
// and ERROR (memory watchdog expiry).
// Optional feature macro: SEQ_PERF_COUNTERS_EN adds cycle/instret counters.
module cpu_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,  // 0 disables the watchdog
  parameter int unsigned COUNTER_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cpu_sequencer_if.master      bus
`ifdef SEQ_PERF_COUNTERS_EN
  ,
  output logic [COUNTER_W-1:0] cycle_count,
  output logic [COUNTER_W-1:0] instret_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5,
    S_ERROR   = 3'd6
  } state_e;

  // Counter only has to reach TIMEOUT_CYCLES-1: the last wait cycle goes
  // straight to ERROR instead of incrementing.
  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          WD_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WD_EN ? WAIT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  // State and watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic; a ready arriving on the expiry cycle still completes
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_FETCH: begin
        if (bus.imem_ready) begin
          state_d = S_DECODE;
          wait_d  = '0;
        end else if (WD_EN && wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
          wait_d  = '0;
        end else if (WD_EN) begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE:  state_d = bus.ebreak ? S_HALT : S_EXECUTE;
      S_EXECUTE: state_d = (bus.load_memory || bus.store_memory) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.dmem_ready) begin
          state_d = S_WB;
          wait_d  = '0;
        end else if (WD_EN && wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
          wait_d  = '0;
        end else if (WD_EN) begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
    endcase
  end

  // Output decodes. Requests depend only on state; rst_n gates imem_req so it
  // drops immediately on reset even though the reset state is FETCH. ir_we
  // is the single-cycle IR capture strobe taken in the imem_ready cycle.
  always_comb begin
    bus.imem_req  = rst_n && (state_q == S_FETCH);
    bus.ir_we     = rst_n && (state_q == S_FETCH) && bus.imem_ready;
    bus.dmem_req  = (state_q == S_MEM);
    bus.dmem_we   = (state_q == S_MEM) && bus.store_memory;
    bus.rf_we     = (state_q == S_WB) && bus.reg_we;
    bus.pc_we     = (state_q == S_WB);
    bus.halted    = (state_q == S_HALT);
    bus.bus_error = (state_q == S_ERROR);
    bus.state_o   = state_q;
  end

`ifdef SEQ_PERF_COUNTERS_EN
  logic [COUNTER_W-1:0] cycle_q, instret_q;

  // Free-running cycle counter and retire counter (retire = WRITEBACK cycle)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
      if (state_q == S_WB) instret_q <= instret_q + 1'b1;
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer. Each instruction is modelled as a
// trace of cycles derived from its class and chosen memory delays.
module tb_cpu_sequencer;
  localparam int T = 4;  // watchdog length used throughout

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_sequencer_if bus ();
`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] cyc_o, ret_o;
`endif

  cpu_sequencer #(.TIMEOUT_CYCLES(T), .COUNTER_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SEQ_PERF_COUNTERS_EN
    ,
    .cycle_count   (cyc_o),
    .instret_count (ret_o)
`endif
  );

  int total = 0;
  int bad   = 0;
  int mcyc  = 0;   // model: cycles since reset release
  int mret  = 0;   // model: retired instructions
  int sticky = 0;  // model: 0 running, 5 halted, 6 bus error

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] obs_vec();
    return {bus.state_o, bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we,
            bus.rf_we, bus.pc_we, bus.halted, bus.bus_error};
  endfunction

  // Expected outputs for a cycle spent in state st
  function automatic logic [10:0] ev(int st, bit irw, bit stw, bit rfw);
    return {3'(st), st == 0, irw, st == 3, (st == 3) && stw, (st == 4) && rfw,
            st == 4, st == 5, st == 6};
  endfunction

  // One clock cycle: drive readies, sample at negedge, advance to posedge+1
  task automatic cyc_step(input string tag, input logic ir, input logic dr,
                          input int st, input bit irw, input bit stw, input bit rfw);
    bus.imem_ready = ir;
    bus.dmem_ready = dr;
    @(negedge clk);
    check(tag, 32'(obs_vec()), 32'(ev(st, irw, stw, rfw)));
`ifdef SEQ_PERF_COUNTERS_EN
    check({tag, "_cycle"}, cyc_o, 32'(mcyc));
    check({tag, "_instret"}, ret_o, 32'(mret));
`endif
    if (st == 4) mret++;
    mcyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic noise();
    return logic'($urandom_range(0, 1));
  endfunction

  // kind: 0 alu, 1 load, 2 store, 3 branch, 4 ebreak
  // df/dm: number of not-ready cycles before imem/dmem ready (>=T times out)
  task automatic run_instr(input int kind, input int df, input int dm);
    bit st, rw;
    st = (kind == 2);
    rw = (kind == 0 || kind == 1);
    bus.load_memory  = (kind == 1);
    bus.store_memory = st;
    bus.reg_we       = rw;
    bus.ebreak       = (kind == 4);
    for (int i = 0; i <= df && i < T; i++)
      cyc_step("fetch", logic'(i == df), noise(), 0, i == df, st, rw);
    if (df >= T) begin sticky = 6; return; end
    cyc_step("decode", noise(), noise(), 1, 0, st, rw);
    if (kind == 4) begin sticky = 5; return; end
    cyc_step("execute", noise(), noise(), 2, 0, st, rw);
    if (kind == 1 || kind == 2) begin
      for (int i = 0; i <= dm && i < T; i++)
        cyc_step("mem", noise(), logic'(i == dm), 3, 0, st, rw);
      if (dm >= T) begin sticky = 6; return; end
    end
    cyc_step("writeback", noise(), noise(), 4, 0, st, rw);
  endtask

  task automatic sticky_steps(input int n);
    for (int i = 0; i < n; i++)
      cyc_step(sticky == 5 ? "halt_sticky" : "error_sticky", noise(), noise(),
               sticky, 0, 0, 0);
  endtask

  // Assert reset between clock edges, check outputs drop at once, release
  task automatic do_reset();
    bus.imem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("reset_outputs", 32'(obs_vec()), 32'(0));
`ifdef SEQ_PERF_COUNTERS_EN
    check("reset_cycle", cyc_o, 32'(0));
    check("reset_instret", ret_o, 32'(0));
`endif
    @(posedge clk);
    #1;
    check("reset_held", 32'(obs_vec()), 32'(0));
    rst_n = 1'b1;
    mcyc = 0;
    mret = 0;
    sticky = 0;
  endtask

  initial begin
    bus.imem_ready = 0; bus.dmem_ready = 0; bus.load_memory = 0;
    bus.store_memory = 0; bus.reg_we = 0; bus.ebreak = 0;
    #2;
    do_reset();

    // zero-wait ALU, delayed load, store, branch
    run_instr(0, 0, 0);
    run_instr(1, 0, 3);
    run_instr(2, 1, 0);
    run_instr(3, 2, 0);
    run_instr(1, 0, 0);

    // ebreak -> sticky HALT with ready pulses ignored
    run_instr(4, 0, 0);
    sticky_steps(4);
    do_reset();

    // fetch watchdog expiry, then ready on the last wait cycle
    run_instr(0, T, 0);
    sticky_steps(3);
    do_reset();
    run_instr(0, T - 1, 0);

    // data watchdog expiry
    run_instr(2, 0, T);
    sticky_steps(2);
    do_reset();

    // async reset mid-MEM
    bus.load_memory = 1; bus.store_memory = 0; bus.reg_we = 1; bus.ebreak = 0;
    cyc_step("mr_fetch", 1, 0, 0, 1, 0, 1);
    cyc_step("mr_decode", 0, 0, 1, 0, 0, 1);
    cyc_step("mr_execute", 0, 0, 2, 0, 0, 1);
    cyc_step("mr_mem", 0, 0, 3, 0, 0, 1);
    bus.dmem_ready = 0;
    #2;
    check("pre_reset_dmem_req", 32'(bus.dmem_req), 32'(1));
    do_reset();
    run_instr(0, 0, 0);

    // randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      int k, df, dm, r;
      k  = int'($urandom_range(0, 4));
      r  = int'($urandom_range(0, 11));
      df = (r < 10) ? (r % T) : T;
      r  = int'($urandom_range(0, 11));
      dm = (r < 10) ? (r % T) : T;
      run_instr(k, df, dm);
      if (sticky != 0) begin
        sticky_steps(2);
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end
endmodule
